// File: rtl/bsg_flow_counter_multi.sv
// Per-channel outstanding-element counter with saturation, occupancy status
// decodes, sticky overflow/underflow flags and per-channel synchronous clear.
module bsg_flow_counter_multi #(
    parameter int channels_p    = 4,
    parameter int els_p         = 64,
    parameter int almost_full_p = els_p - 4,
    localparam int lg_els_lp    = $clog2(els_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [channels_p-1:0]           v_i,
    input  logic [channels_p-1:0]           ready_i,
    input  logic [channels_p-1:0]           yumi_i,
    input  logic [channels_p-1:0]           clear_i,
    input  logic                            err_clear_i,
    output logic [channels_p*lg_els_lp-1:0] count_o,
    output logic [channels_p-1:0]           empty_o,
    output logic [channels_p-1:0]           full_o,
    output logic [channels_p-1:0]           almost_full_o,
    output logic [channels_p-1:0]           overflow_o,
    output logic [channels_p-1:0]           underflow_o
);

    if (almost_full_p < 1 || almost_full_p > els_p) begin : g_bad_almost_full
        $error("bsg_flow_counter_multi: almost_full_p must lie in 1..els_p");
    end

    localparam logic [lg_els_lp-1:0] els_lp = lg_els_lp'(els_p);
    localparam logic [lg_els_lp-1:0] af_lp  = lg_els_lp'(almost_full_p);
    localparam logic [lg_els_lp-1:0] one_lp = lg_els_lp'(1);

    logic [lg_els_lp-1:0] count_q [channels_p];
    logic [lg_els_lp-1:0] count_d [channels_p];
    logic [channels_p-1:0] overflow_q, overflow_d;
    logic [channels_p-1:0] underflow_q, underflow_d;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q & ~{channels_p{err_clear_i}};
        underflow_d = underflow_q & ~{channels_p{err_clear_i}};
        for (int c = 0; c < channels_p; c++) begin
            // Clear beats traffic; a simultaneous enq and yumi is a bypass and never an error.
            if (clear_i[c]) begin
                count_d[c] = '0;
            end else if (v_i[c] && ready_i[c] && !yumi_i[c]) begin
                if (count_q[c] == els_lp) overflow_d[c] = 1'b1;
                else                      count_d[c]    = count_q[c] + one_lp;
            end else if (yumi_i[c] && !(v_i[c] && ready_i[c])) begin
                if (count_q[c] == '0) underflow_d[c] = 1'b1;
                else                  count_d[c]     = count_q[c] - one_lp;
            end
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < channels_p; c++) count_q[c] <= '0;
            overflow_q  <= '0;
            underflow_q <= '0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        count_o       = '0;
        empty_o       = '0;
        full_o        = '0;
        almost_full_o = '0;
        for (int c = 0; c < channels_p; c++) begin
            count_o[c*lg_els_lp +: lg_els_lp] = count_q[c];
            empty_o[c]       = (count_q[c] == '0);
            full_o[c]        = (count_q[c] == els_lp);
            almost_full_o[c] = (count_q[c] >= af_lp);
        end
        overflow_o  = overflow_q;
        underflow_o = underflow_q;
    end

endmodule

// File: tb/tb_bsg_flow_counter_multi.sv
// Self-checking bench for bsg_flow_counter_multi at default parameters:
// directed table, hand-written corner sequences and randomized traffic against a model.
module tb_bsg_flow_counter_multi;

    localparam int CH = 4;
    localparam int ELS = 64;
    localparam int AF = 60;
    localparam int W = 7;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [CH-1:0]   v_i, ready_i, yumi_i, clear_i;
    logic            err_clear_i;
    logic [CH*W-1:0] count_o;
    logic [CH-1:0]   empty_o, full_o, almost_full_o, overflow_o, underflow_o;

    bsg_flow_counter_multi dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .ready_i      (ready_i),
        .yumi_i       (yumi_i),
        .clear_i      (clear_i),
        .err_clear_i  (err_clear_i),
        .count_o      (count_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .almost_full_o(almost_full_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: plain integer occupancy per channel plus sticky error bits.
    int m_cnt [CH];
    bit m_ovf [CH];
    bit m_unf [CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [CH-1:0] v, r, y, clr, input logic errc, rst);
        for (int c = 0; c < CH; c++) begin
            bit enq, deq, ovf_evt, unf_evt;
            enq = v[c] && r[c];
            deq = y[c];
            ovf_evt = 0;
            unf_evt = 0;
            if (rst) begin
                m_cnt[c] = 0;
                m_ovf[c] = 0;
                m_unf[c] = 0;
                continue;
            end
            if (clr[c]) begin
                m_cnt[c] = 0;
            end else begin
                int delta;
                delta = int'(enq) - int'(deq);
                if (m_cnt[c] + delta > ELS) ovf_evt = 1;
                else if (m_cnt[c] + delta < 0) unf_evt = 1;
                else m_cnt[c] = m_cnt[c] + delta;
            end
            m_ovf[c] = (m_ovf[c] && !errc) || ovf_evt;
            m_unf[c] = (m_unf[c] && !errc) || unf_evt;
        end
    endtask

    function automatic logic [CH*W-1:0] m_counts();
        logic [CH*W-1:0] res;
        for (int c = 0; c < CH; c++) res[c*W +: W] = W'(m_cnt[c]);
        return res;
    endfunction

    task automatic check_model(input string tag);
        logic [CH-1:0] e, f, a, o, u;
        for (int c = 0; c < CH; c++) begin
            e[c] = (m_cnt[c] == 0);
            f[c] = (m_cnt[c] == ELS);
            a[c] = (m_cnt[c] >= AF);
            o[c] = m_ovf[c];
            u[c] = m_unf[c];
        end
        check({tag, ".count"}, 32'(count_o), 32'(m_counts()));
        check({tag, ".empty"}, 32'(empty_o), 32'(e));
        check({tag, ".full"}, 32'(full_o), 32'(f));
        check({tag, ".almost_full"}, 32'(almost_full_o), 32'(a));
        check({tag, ".overflow"}, 32'(overflow_o), 32'(o));
        check({tag, ".underflow"}, 32'(underflow_o), 32'(u));
    endtask

    // Drive one cycle, advance the model with the same inputs, sample 1 time unit after the edge.
    task automatic apply(input logic [CH-1:0] v, r, y, clr, input logic errc, rst);
        v_i = v;
        ready_i = r;
        yumi_i = y;
        clear_i = clr;
        err_clear_i = errc;
        reset_i = rst;
        @(posedge clk_i);
        model_step(v, r, y, clr, errc, rst);
        #1;
    endtask

    task automatic idle();
        apply('0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [CH-1:0]        v, r, y, clr;
        logic                 errc;
        logic [CH-1:0][W-1:0] exp_cnt;
        logic [CH-1:0]        exp_ovf;
        logic [CH-1:0]        exp_unf;
        string                name;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic [CH-1:0] v, r, y, clr, input logic errc,
                                input int c3, c2, c1, c0, input logic [CH-1:0] o, u,
                                input string name);
        vec_t t;
        t.v = v; t.r = r; t.y = y; t.clr = clr; t.errc = errc;
        t.exp_cnt = {W'(c3), W'(c2), W'(c1), W'(c0)};
        t.exp_ovf = o; t.exp_unf = u; t.name = name;
        return t;
    endfunction

    initial begin
        v_i = '0; ready_i = '0; yumi_i = '0; clear_i = '0; err_clear_i = 1'b0; reset_i = 1'b1;
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_ovf[c] = 0; m_unf[c] = 0;
        end

        // Reset state after 10 idle cycles.
        apply('0, '0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) idle();
        check("rst.count", 32'(count_o), 32'h0);
        check("rst.empty", 32'(empty_o), 32'hf);
        check("rst.full", 32'(full_o), 32'h0);
        check("rst.almost_full", 32'(almost_full_o), 32'h0);
        check("rst.overflow", 32'(overflow_o), 32'h0);
        check("rst.underflow", 32'(underflow_o), 32'h0);

        // Channel 0 fill through the almost-full threshold to saturation.
        for (int i = 0; i < 59; i++) apply(4'b0001, 4'b0001, '0, '0, 1'b0, 1'b0);
        check("fill59.count0", 32'(count_o[W-1:0]), 32'd59);
        check("fill59.af0", 32'(almost_full_o[0]), 32'd0);
        apply(4'b0001, 4'b0001, '0, '0, 1'b0, 1'b0);
        check("fill60.count0", 32'(count_o[W-1:0]), 32'd60);
        check("fill60.af0", 32'(almost_full_o[0]), 32'd1);
        check("fill60.full0", 32'(full_o[0]), 32'd0);
        for (int i = 0; i < 4; i++) apply(4'b0001, 4'b0001, '0, '0, 1'b0, 1'b0);
        check("fill64.count0", 32'(count_o[W-1:0]), 32'd64);
        check("fill64.full0", 32'(full_o[0]), 32'd1);
        check("fill64.ovf", 32'(overflow_o), 32'h0);
        apply(4'b0001, 4'b0001, '0, '0, 1'b0, 1'b0);
        check("sat.count", 32'(count_o), 32'd64);
        check("sat.ovf", 32'(overflow_o), 32'h1);

        // Directed table; counts listed as ch3, ch2, ch1, ch0.
        vecs.push_back(mk('0, '0, 4'b0010, '0, 0, 0, 0, 0, 64, 4'b0001, 4'b0010, "unf1"));
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0010, '0, 0, 0, 0, 0, 64, 4'b0001, 4'b0010, "bypass1_at0"));
        vecs.push_back(mk('0, '0, '0, '0, 1, 0, 0, 0, 64, 4'b0000, 4'b0000, "errclr"));
        vecs.push_back(mk(4'b0010, 4'b0000, '0, '0, 0, 0, 0, 0, 64, 4'b0000, 4'b0000, "v_no_ready"));
        vecs.push_back(mk(4'b0000, 4'b0010, '0, '0, 0, 0, 0, 0, 64, 4'b0000, 4'b0000, "ready_no_v"));
        vecs.push_back(mk(4'b1100, 4'b1100, '0, '0, 0, 1, 1, 0, 64, 4'b0000, 4'b0000, "enq23_a"));
        vecs.push_back(mk(4'b1100, 4'b1100, '0, '0, 0, 2, 2, 0, 64, 4'b0000, 4'b0000, "enq23_b"));
        vecs.push_back(mk(4'b1100, 4'b1100, '0, '0, 0, 3, 3, 0, 64, 4'b0000, 4'b0000, "enq23_c"));
        vecs.push_back(mk(4'b0100, 4'b0100, '0, '0, 0, 3, 4, 0, 64, 4'b0000, 4'b0000, "enq2_d"));
        vecs.push_back(mk(4'b0100, 4'b0100, '0, '0, 0, 3, 5, 0, 64, 4'b0000, 4'b0000, "enq2_e"));
        vecs.push_back(mk(4'b1100, 4'b1100, 4'b1000, 4'b0100, 0, 3, 0, 0, 64, 4'b0000, 4'b0000, "clr2_bypass3"));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, '0, 0, 3, 0, 0, 64, 4'b0000, 4'b0000, "bypass0_at_full"));
        vecs.push_back(mk(4'b0001, 4'b0001, '0, '0, 1, 3, 0, 0, 64, 4'b0001, 4'b0000, "set_wins"));
        vecs.push_back(mk('0, '0, 4'b1000, '0, 0, 2, 0, 0, 64, 4'b0001, 4'b0000, "deq3"));
        vecs.push_back(mk('0, '0, 4'b0100, 4'b0100, 0, 2, 0, 0, 64, 4'b0001, 4'b0000, "clr_masks_unf"));

        foreach (vecs[i]) begin
            apply(vecs[i].v, vecs[i].r, vecs[i].y, vecs[i].clr, vecs[i].errc, 1'b0);
            check({vecs[i].name, ".count"}, 32'(count_o), 32'(vecs[i].exp_cnt));
            check({vecs[i].name, ".ovf"}, 32'(overflow_o), 32'(vecs[i].exp_ovf));
            check({vecs[i].name, ".unf"}, 32'(underflow_o), 32'(vecs[i].exp_unf));
        end

        // Build counts 3, 7, 64, 1 on channels 0..3, then reset mid-traffic.
        apply('0, '0, '0, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            logic [CH-1:0] m;
            m = {1'(i < 1), 1'b1, 1'(i < 7), 1'(i < 3)};
            apply(m, m, '0, '0, 1'b0, 1'b0);
        end
        apply(4'b0100, 4'b0100, 4'b0010, '0, 1'b0, 1'b0);
        check_model("pre_reset");
        check("pre_reset.count", 32'(count_o), {4'h0, 7'd1, 7'd64, 7'd6, 7'd3});
        apply(4'b1111, 4'b1111, 4'b0101, '0, 1'b0, 1'b1);
        check("mid_reset.count", 32'(count_o), 32'h0);
        check("mid_reset.empty", 32'(empty_o), 32'hf);
        check("mid_reset.flags", 32'({overflow_o, underflow_o}), 32'h0);

        // Randomized traffic in alternating fill / drain phases.
        for (int i = 0; i < 4000; i++) begin
            logic [CH-1:0] v, r, y, clr;
            logic errc, rst;
            bit fill;
            fill = ((i / 300) % 2) == 0;
            v = CH'($urandom);
            r = fill ? (CH'($urandom) | CH'($urandom)) : CH'($urandom);
            y = fill ? (CH'($urandom) & CH'($urandom) & CH'($urandom)) : (CH'($urandom) | CH'($urandom));
            clr = ($urandom_range(0, 199) == 0) ? CH'($urandom) : '0;
            errc = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 999) == 0);
            apply(v, r, y, clr, errc, rst);
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
